// File: rtl/if_stage_ctrl_pkg.sv
// Shared types for the fetch-stage sequencer: FSM state encoding and the NOP word
// that IF/ID holds after a flush.
package if_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MISS = 2'd2,
    ST_DROP = 2'd3
  } if_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_stage_ctrl_sat_counter.sv
// Enable-gated up-counter that sticks at all-ones instead of wrapping.
module if_stage_ctrl_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;

  // count enabled cycles, holding at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/if_stage_ctrl.sv
// Fetch-stage sequencer: arbitrates load-use stall, ID-stage branch redirect and
// multi-cycle imem misses. Define IF_CTRL_PERF_EN to build the stall/flush counters.
module if_stage_ctrl
  import if_stage_ctrl_pkg::*;
#(
  parameter int RS_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [RS_W-1:0]  id_rs1_i,
  input  logic [RS_W-1:0]  id_rs2_i,
  input  logic [RS_W-1:0]  ex_rd_i,
  input  logic             ex_memread_i,
  input  logic             branch_taken_i,
  output logic             imem_req_o,
  input  logic             imem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  if_state_e state_r;
  logic      lu_s;
  logic      req_s, pcw_s, stall_s, flush_s, bubble_s;

  assign lu_s = ex_memread_i && (ex_rd_i != {RS_W{1'b0}}) &&
                ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  // state sequencing; dropping start_i parks the stage from any state
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else if (!start_i) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_r <= ST_RUN;
        ST_RUN: begin
          if (lu_s)                state_r <= ST_RUN;
          else if (branch_taken_i) state_r <= imem_ready_i ? ST_RUN : ST_DROP;
          else if (!imem_ready_i)  state_r <= ST_MISS;
          else                     state_r <= ST_RUN;
        end
        ST_MISS: begin
          if (lu_s)                state_r <= ST_MISS;
          else if (branch_taken_i) state_r <= ST_DROP;
          else if (imem_ready_i)   state_r <= ST_RUN;
          else                     state_r <= ST_MISS;
        end
        ST_DROP: state_r <= imem_ready_i ? ST_RUN : ST_DROP;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // pipeline controls; stall always wins over flush so both are never set together
  always_comb begin
    req_s    = 1'b0;
    pcw_s    = 1'b0;
    stall_s  = 1'b0;
    flush_s  = 1'b0;
    bubble_s = 1'b0;
    case (state_r)
      ST_RUN, ST_MISS: begin
        req_s = 1'b1;
        if (lu_s) begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
        end else if (branch_taken_i) begin
          pcw_s   = 1'b1;
          flush_s = 1'b1;
        end else if (imem_ready_i) begin
          pcw_s = 1'b1;
        end else begin
          flush_s = 1'b1;
        end
      end
      ST_DROP: begin
        req_s = 1'b1;
        if (lu_s) begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
        end else begin
          flush_s = 1'b1;
        end
      end
      default: begin
        flush_s = 1'b1;
      end
    endcase
  end

  assign imem_req_o    = req_s;
  assign pc_write_o    = pcw_s;
  assign ifid_stall_o  = stall_s;
  assign ifid_flush_o  = flush_s;
  assign idex_bubble_o = bubble_s;

`ifdef IF_CTRL_PERF_EN
  logic active_s;
  assign active_s = (state_r != ST_IDLE);

  if_stage_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (active_s && !pcw_s),
    .cnt   (stall_cnt_o)
  );

  if_stage_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (active_s && flush_s),
    .cnt   (flush_cnt_o)
  );
`else
  assign stall_cnt_o = {CNT_W{1'b0}};
  assign flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl; counter expectations follow IF_CTRL_PERF_EN.
module tb_if_stage_ctrl;

`ifdef IF_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, start_i;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        ex_memread_i, branch_taken_i, imem_ready_i;
  logic        imem_req_o, pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  int checks = 0;
  int failures = 0;

  if_stage_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .ex_rd_i        (ex_rd_i),
    .ex_memread_i   (ex_memread_i),
    .branch_taken_i (branch_taken_i),
    .imem_req_o     (imem_req_o),
    .imem_ready_i   (imem_ready_i),
    .pc_write_o     (pc_write_o),
    .ifid_stall_o   (ifid_stall_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // apply ID/EX inputs and let the combinational outputs settle
  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic br, input logic rdy);
    ex_memread_i   = mr;
    ex_rd_i        = rd;
    id_rs1_i       = rs1;
    id_rs2_i       = rs2;
    branch_taken_i = br;
    imem_ready_i   = rdy;
    #1;
  endtask

  task automatic check_out(input string tag, input logic req, input logic pcw,
                           input logic stall, input logic flush, input logic bubble);
    check({tag, ".req"},    {31'd0, imem_req_o},    {31'd0, req});
    check({tag, ".pcw"},    {31'd0, pc_write_o},    {31'd0, pcw});
    check({tag, ".stall"},  {31'd0, ifid_stall_o},  {31'd0, stall});
    check({tag, ".flush"},  {31'd0, ifid_flush_o},  {31'd0, flush});
    check({tag, ".bubble"}, {31'd0, idex_bubble_o}, {31'd0, bubble});
  endtask

  task automatic check_cnt(input string tag, input int s, input int f);
    check({tag, ".stall_cnt"}, {16'd0, stall_cnt_o}, PERF ? s : 32'd0);
    check({tag, ".flush_cnt"}, {16'd0, flush_cnt_o}, PERF ? f : 32'd0);
  endtask

  initial begin
    rst_i   = 1'b0;
    start_i = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    tick();
    check_out("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_cnt("reset", 0, 0);

    rst_i = 1'b1;
    tick();
    check_out("idle_nostart", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    start_i = 1'b1;
    tick();
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1);
    check_out("run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    drive(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1);
    check_out("lu", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check_out("lu_rd0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
    check_out("br_run", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b1);
    check_out("br_lu", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1);
    check_out("run_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_cnt("pre_miss", 2, 1);

    // fresh counters for the miss scenario
    rst_i = 1'b0;
    #1;
    check_cnt("rst_clear", 0, 0);
    rst_i = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
      check_out($sformatf("miss%0d", i), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1);
    check_out("miss_ready", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_cnt("miss_ready", 3, 3);
    tick();
    check_out("back_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // enter MISS, then branch out to DROP
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
    check_out("miss_br", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
    check_out("drop_br_ign", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd3, 5'd2, 1'b0, 1'b0);
    check_out("drop_lu", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1);
    check_out("drop_discard", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("drop_to_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_cnt("drop_to_run", 7, 7);

    // asynchronous reset in the middle of a miss
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    tick();
    check_out("pre_rst_miss", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_i = 1'b0;
    #1;
    check_out("rst_mid_miss", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_cnt("rst_mid_miss", 0, 0);
    rst_i = 1'b1;
    tick();
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1);
    check_out("restart", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    start_i = 1'b0;
    tick();
    check_out("stop_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_cnt("stop_idle", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
